// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised RAM slave behind a valid/ready handshake,
// with byte/half/word accesses, RISC-V load extension and programmable wait states.
module data_mem_responder #(
  parameter int WIDTH_DATA  = 32,
  parameter int WIDTH_ADDR  = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [WIDTH_ADDR-1:0] req_addr,
  input  logic [WIDTH_DATA-1:0] req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH_DATA-1:0] rsp_rdata,
  output logic                  rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [WIDTH_ADDR-1:0] addr_q, addr_d;
  logic [WIDTH_DATA-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]            size_q, size_d;
  logic [WIDTH_DATA-1:0] mem_q [DEPTH_WORDS];
  logic [WIDTH_DATA-1:0] mem_d [DEPTH_WORDS];
  logic [AW-1:0]         idx;
  logic                  acc_err;
  logic [3:0]            be;
  logic [WIDTH_DATA-1:0] rd_word, sh, wsh, wr_word, ld_data;
  assign req_ready = state_q == S_IDLE;
  assign rsp_valid = state_q == S_RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  // Access datapath, evaluated on the captured request fields.
  always_comb begin
    idx     = addr_q[AW+1:2];
    acc_err = (size_q == 2'b11) || (size_q == 2'b01 && addr_q[0]) ||
              (size_q == 2'b10 && addr_q[1:0] != 2'b00) || ((addr_q >> (AW + 2)) != '0);
    be      = size_q == 2'b00 ? 4'b0001 << addr_q[1:0] :
              size_q == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wsh     = size_q == 2'b00 ? {4{wdata_q[7:0]}} :
              size_q == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    rd_word = mem_q[idx];
    sh      = rd_word >> {addr_q[1:0], 3'b000};
    ld_data = size_q == 2'b00 ? {{24{sh[7] & ~uns_q}}, sh[7:0]} :
              size_q == 2'b01 ? {{16{sh[15] & ~uns_q}}, sh[15:0]} : rd_word;
    wr_word = rd_word;
    for (int b = 0; b < 4; b++)
      wr_word[8*b +: 8] = be[b] ? wsh[8*b +: 8] : rd_word[8*b +: 8];
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_d   = mem_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        we_d    = req_we;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        size_d  = req_size;
        uns_d   = req_unsigned;
        cnt_d   = 4'(WAIT_CYCLES);
        state_d = S_WAIT;
      end
      S_WAIT: if (cnt_q == 4'd0) begin
        state_d = S_RESP;
        err_d   = acc_err;
        rdata_d = (acc_err || we_q) ? '0 : ld_data;
        if (we_q && !acc_err) mem_d[idx] = wr_word;
      end else cnt_d = cnt_q - 4'd1;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vectors with hand-computed expectations for data_mem_responder.
module tb_data_mem_responder;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = 2'b10;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int          checks = 0, failures = 0;
  always #5 clk = ~clk;
  data_mem_responder #(.WIDTH_DATA(32), .WIDTH_ADDR(32), .DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic u);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = u;
  endtask
  // Issues one request, waits (bounded) for the response, checks data/err/latency, completes handshake.
  task automatic xact(input string tag, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic u, input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    @(negedge clk);
    drive(we, a, wd, sz, u);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    xact("lw0", 1'b0, 32'h00, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
    xact("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0);
    xact("lw10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
    xact("sw20", 1'b1, 32'h20, 32'h80FF7F01, 2'b10, 1'b0, 32'h0, 1'b0);
    xact("lb23", 1'b0, 32'h23, 32'h0, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
    xact("lbu23", 1'b0, 32'h23, 32'h0, 2'b00, 1'b1, 32'h00000080, 1'b0);
    xact("lb21", 1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 32'h0000007F, 1'b0);
    xact("lh22", 1'b0, 32'h22, 32'h0, 2'b01, 1'b0, 32'hFFFF80FF, 1'b0);
    xact("lhu20", 1'b0, 32'h20, 32'h0, 2'b01, 1'b1, 32'h00007F01, 1'b0);
    xact("sb21", 1'b1, 32'h21, 32'hFFFFFFAA, 2'b00, 1'b0, 32'h0, 1'b0);
    xact("lw20a", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h80FFAA01, 1'b0);
    xact("sh12", 1'b1, 32'h12, 32'h1234CAFE, 2'b01, 1'b0, 32'h0, 1'b0);
    xact("lw10b", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hCAFEBEEF, 1'b0);
    xact("lh21_err", 1'b0, 32'h21, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1);
    xact("sw22_err", 1'b1, 32'h22, 32'h11111111, 2'b10, 1'b0, 32'h0, 1'b1);
    xact("sz11_err", 1'b0, 32'h20, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
    xact("sz11st_err", 1'b1, 32'h20, 32'h22222222, 2'b11, 1'b0, 32'h0, 1'b1);
    xact("lw20b", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h80FFAA01, 1'b0);
    xact("lw100_err", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
    xact("sw100_err", 1'b1, 32'h100, 32'h33333333, 2'b10, 1'b0, 32'h0, 1'b1);
    xact("lw0b", 1'b0, 32'h00, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
    // Backpressure: response held five cycles while a competing store is presented.
    @(negedge clk);
    drive(1'b0, 32'h20, 32'h0, 2'b00, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 32'h10, 32'h55555555, 2'b10, 1'b0);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, 32'h00000001);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_done_valid", 32'(rsp_valid), 32'd0);
    chk("bp_done_ready", 32'(req_ready), 32'd1);
    xact("lw10c", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hCAFEBEEF, 1'b0);
    // Reset pulsed while a store waits: store must be discarded.
    @(negedge clk);
    drive(1'b1, 32'h30, 32'h12345678, 2'b10, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_busy", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xact("lw30", 1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
    xact("lw20_rst", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder end of the core's data-memory interface: a word-organised RAM slave behind a valid/ready request/response handshake.
- Supports byte, halfword and word accesses with RISC-V sign/zero extension for loads.
- Inserts a programmable number of wait states.
- Replaces the single-cycle data memory so the pipeline can be tested against multi-cycle memory.

Parameters:
- WIDTH_DATA, 32, data width; fixed at 32 (byte-lane logic assumes 4 lanes).
- WIDTH_ADDR, 32, request byte-address width.
- DEPTH_WORDS, 64, number of 32-bit words; power of two, ≥2.
- WAIT_CYCLES, 2, wait states between accept and access; 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  WIDTH_ADDR  byte address.
- req_wdata  in  WIDTH_DATA  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1 (LBU/LHU); ignored for stores and words.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  WIDTH_DATA  load data, extended; 0 for stores and errors.
- rsp_err  out  1  request faulted (misaligned, out of range, illegal size).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Wait counter=0, all memory words=0.
  - Takes effect immediately, mid-transaction included; a pending store not yet committed is discarded.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid=1 at a clock edge, capture we/addr/wdata/size/unsigned. Go to WAIT with counter=WAIT_CYCLES; if WAIT_CYCLES=0, go directly to the access step (below) in the same edge-to-edge cycle.
  - WAIT: req_ready=0. Decrement counter each cycle. The access step occurs on the edge where counter==0 → RESP.
  - RESP: req_ready=0, rsp_valid=1. rsp_rdata/rsp_err stay stable until rsp_ready=1 at an edge → IDLE, rsp_valid=0.
- Handshake: no request is accepted while a transaction is outstanding; one transaction in flight max. req_ready is combinational from state only, never from req_valid.
- Latency: request accepted at edge N → rsp_valid high after edge N+WAIT_CYCLES+1, i.e. 1 cycle for WAIT_CYCLES=0. Earliest next accept is the edge after the response handshake edge, because req_ready returns high in IDLE.
- Access step, evaluated on captured fields:
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Error if size==11, or size==01 and addr[0]=1, or size==10 and addr[1:0]≠0, or addr[WIDTH_ADDR-1:log2(DEPTH_WORDS)+2] ≠ 0.
  - On error: no memory change, rsp_err=1, rsp_rdata=0.
- Store:
  - Byte writes lane addr[1:0] with wdata[7:0].
  - Half writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - Word writes all lanes.
  - Other lanes unchanged. rsp_rdata=0, rsp_err=0.
- Load:
  - Select lane(s) as for stores and right-align.
  - Sign-extend from bit 7/15 unless req_unsigned=1 (zero-extend). Words are returned unchanged.
- Memory is read only at the access step. A store immediately followed by a load to the same word returns the new data.
- Simultaneous events:
  - rsp_ready high outside RESP is ignored.
  - req_valid during WAIT/RESP is ignored and not queued; the requester must hold it.

Test Plan:
- Reset then idle: rst_n low 2 cycles → req_ready=1, rsp_valid=0; a word load from 0x00 returns 0x00000000, err=0.
- Word store/load, WAIT_CYCLES=2: SW 0xDEADBEEF @0x10 accepted at edge N → rsp_valid at edge N+3. LW @0x10 → rsp_rdata=0xDEADBEEF.
- Sub-word: after SW 0x80FF7F01 @0x20:
  - LB @0x23 → 0xFFFFFF80; LBU @0x23 → 0x00000080.
  - LH @0x22 → 0xFFFF80FF; LHU @0x20 → 0x00007F01.
  - SB 0xAA @0x21, then LW @0x20 → 0x80FFAA01.
- Errors:
  - LH @0x21, SW @0x22, size=11 → rsp_err=1, rsp_rdata=0, memory unchanged.
  - Address 0x100 with DEPTH_WORDS=64 → rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid and data stable, req_ready=0, concurrent req_valid not accepted. rsp_ready=1 → IDLE the next cycle.
- Reset mid-op: SW 0x12345678 @0x30 accepted, rst_n pulsed during WAIT → outputs at reset values; LW @0x30 → 0x00000000.
